usart_recv_frame: RTL

Receive-side counterpart of the 5-byte status frame sent by the UART transmitter. Deserialises 8N1 bytes from `uart_rxd` and validates the fixed frame layout: address byte, mode byte, then D[23:16], D[15:8], D[7:0]. On each complete good frame it updates `Adress`, `Mod_SEL` and `D` and pulses `frame_valid`. Sits at the host/peer end of the serial link, or in loopback benches against the transmitter.

---
 rtl/usart_pkg.sv | 27 ++
 rtl/usart_recv_frame_uart_recv.sv | 119 +++++++++++
 rtl/usart_recv_frame.sv | 126 ++++++++++++
 3 files changed

// File: rtl/usart_pkg.sv
// Shared constants and state encodings for the
// usart_recv_frame receive path.
package usart_pkg;

  localparam logic [15:0] BPS_CNT_DEF = 16'd434;
  localparam logic [15:0] TIMEOUT_DEF = 16'd12000;

  localparam int FRAME_BYTES = 5;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMMIT
  } frame_state_e;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_BREAK
  } rx_state_e;

endpackage

// File: rtl/usart_recv_frame_uart_recv.sv
// 8N1 byte receiver: synchroniser, start-edge
// detect and mid-bit sampling FSM.
module uart_recv
  import usart_pkg::*;
#(
  parameter logic [15:0] BPS_CNT = BPS_CNT_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic       byte_done,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam logic [15:0] HALF =
    (BPS_CNT >> 1) - 16'd1;
  localparam logic [15:0] FULL =
    BPS_CNT - 16'd1;

  logic       rx_s1, rx_s2, rx_d;
  logic       fall;
  rx_state_e  st, st_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0] bitn, bitn_n;
  logic [7:0] sh, sh_n;
  logic       done_n, err_n;

  assign fall = rx_d & ~rx_s2;
  assign byte_data = sh;

  // two-stage synchroniser plus edge register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rxd;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // bit FSM state and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st        <= R_IDLE;
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      byte_done <= 1'b0;
      byte_err  <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      bitn      <= bitn_n;
      sh        <= sh_n;
      byte_done <= done_n;
      byte_err  <= err_n;
    end
  end

  // next-state: start check, data shift, stop check
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    bitn_n = bitn;
    sh_n   = sh;
    done_n = 1'b0;
    err_n  = 1'b0;
    unique case (st)
      R_IDLE: begin
        if (fall) begin
          st_n  = R_START;
          cnt_n = '0;
        end
      end
      R_START: begin
        if (cnt == HALF) begin
          cnt_n  = '0;
          bitn_n = '0;
          st_n   = rx_s2 ? R_IDLE : R_DATA;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      R_DATA: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          sh_n  = {rx_s2, sh[7:1]};
          if (bitn == 3'd7) st_n = R_STOP;
          else bitn_n = bitn + 3'd1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      R_STOP: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          if (rx_s2) begin
            done_n = 1'b1;
            st_n   = R_IDLE;
          end else begin
            err_n = 1'b1;
            st_n  = R_BREAK;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      R_BREAK: begin
        if (rx_s2) st_n = R_IDLE;
      end
      default: st_n = R_IDLE;
    endcase
  end

endmodule

// File: rtl/usart_recv_frame.sv
// Frame assembler: collects 5 bytes, validates the
// header and updates the held status outputs.
module usart_recv_frame
  import usart_pkg::*;
#(
  parameter logic [15:0] BPS_CNT = BPS_CNT_DEF,
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rxd,
  output logic [1:0]  Adress,
  output logic [5:0]  Mod_SEL,
  output logic [23:0] D,
  output logic        frame_valid,
  output logic        frame_err
);

  logic        byte_done, byte_err;
  logic [7:0]  byte_data;
  frame_state_e st, st_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [7:0]  hold [FRAME_BYTES-1];
  logic        ok_q, hdr_ok;
  logic        store, last, tmo;
  logic [15:0] tcnt;

  uart_recv #(
    .BPS_CNT(BPS_CNT)
  ) u_rx (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst),
    .uart_rxd (uart_rxd),
    .byte_done(byte_done),
    .byte_data(byte_data),
    .byte_err (byte_err)
  );

  assign hdr_ok = (hold[0][7:2] == 6'd0) &&
                  (hold[1][7:6] == 2'd0);
  assign tmo = (st == COLLECT) &&
               (tcnt == TIMEOUT);

  // assembler state, index and timeout counter
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      st   <= IDLE;
      idx  <= '0;
      tcnt <= '0;
    end else begin
      st  <= st_n;
      idx <= idx_n;
      if (byte_done || st != COLLECT) tcnt <= '0;
      else tcnt <= tcnt + 16'd1;
    end
  end

  // byte buffer and held outputs; outputs change
  // together with the COMMIT pulse
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < FRAME_BYTES - 1; i++)
        hold[i] <= '0;
      ok_q    <= 1'b0;
      Adress  <= '0;
      Mod_SEL <= '0;
      D       <= '0;
    end else begin
      if (store) hold[idx[1:0]] <= byte_data;
      if (last) begin
        ok_q <= hdr_ok;
        if (hdr_ok) begin
          Adress  <= hold[0][1:0];
          Mod_SEL <= hold[1][5:0];
          D       <= {hold[2], hold[3], byte_data};
        end
      end
    end
  end

  // next-state and pulse outputs; byte_done beats timeout
  always_comb begin
    st_n        = st;
    idx_n       = idx;
    store       = 1'b0;
    last        = 1'b0;
    frame_valid = 1'b0;
    frame_err   = 1'b0;
    unique case (st)
      IDLE: begin
        idx_n = '0;
        if (byte_done) begin
          store = 1'b1;
          idx_n = IDX_W'(1);
          st_n  = COLLECT;
        end else if (byte_err) begin
          frame_err = 1'b1;
        end
      end
      COLLECT: begin
        if (byte_done) begin
          if (idx == LAST_IDX) begin
            last  = 1'b1;
            idx_n = '0;
            st_n  = COMMIT;
          end else begin
            store = 1'b1;
            idx_n = idx + IDX_W'(1);
          end
        end else if (byte_err || tmo) begin
          frame_err = 1'b1;
          idx_n     = '0;
          st_n      = IDLE;
        end
      end
      COMMIT: begin
        frame_valid = ok_q;
        frame_err   = ~ok_q;
        idx_n       = '0;
        st_n        = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

endmodule
